// File: rtl/mantissa_normalizer.sv
// Post-adder normalizer: resolves carry/borrow, restores magnitude, left-normalizes.
// Optional macro NORM_SHIFT4_EN enables a 4-bit shift step in SHIFT (results unchanged).
module mantissa_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_cout,
  input  logic              in_op,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              out_underflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  state_t             state_q, state_d;
  logic [MANT_W-1:0]  mant_q, mant_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               sign_q, sign_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic               carry, borrow;
  logic [MANT_W-1:0]  mag;
  logic [EXP_W-1:0]   exp_inc;
  logic [MANT_W-1:0]  mant_sh;
  logic [EXP_W-1:0]   exp_sh;

  always_comb begin
    carry   = ~in_op & in_cout;
    borrow  = in_op & ~in_cout;
    mag     = borrow ? (~in_mant + 1'b1) : in_mant;
    exp_inc = in_exp + 1'b1;
  end

  // One normalization step from the current registered mantissa/exponent.
  always_comb begin
    mant_sh = mant_q << 1;
    exp_sh  = exp_q - 1'b1;
`ifdef NORM_SHIFT4_EN
    if (mant_q[MANT_W-1 -: 4] == 4'b0 && exp_q > EXP_W'(5)) begin
      mant_sh = mant_q << 4;
      exp_sh  = exp_q - EXP_W'(4);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          sign_d  = in_sign ^ borrow;
          mant_d  = mag;
          exp_d   = in_exp;
          state_d = DONE;
          if (carry) begin
            mant_d = {1'b1, in_mant[MANT_W-1:1]};
            exp_d  = exp_inc;
            if (exp_inc == EXP_ONES) begin
              ovf_d  = 1'b1;
              mant_d = '0;
            end
          end else if (mag == '0) begin
            zero_d = 1'b1;
            exp_d  = '0;
            mant_d = '0;
          end else if (mag[MANT_W-1]) begin
            state_d = DONE;
          end else if (in_exp <= EXP_ONE) begin
            unf_d = 1'b1;
            exp_d = '0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mant_d = mant_sh;
        exp_d  = exp_sh;
        if (mant_sh[MANT_W-1]) begin
          state_d = DONE;
        end else if (exp_sh == EXP_ONE) begin
          // Ran out of exponent before finding the leading 1: denormal.
          exp_d   = '0;
          unf_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_mant      = mant_q;
  assign out_exp       = exp_q;
  assign out_sign      = sign_q;
  assign out_zero      = zero_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed self-checking bench for mantissa_normalizer.
module tb_mantissa_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [23:0] in_mant;
  logic        in_cout, in_op, in_sign;
  logic [7:0]  in_exp;
  logic        out_valid, out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign, out_zero, out_overflow, out_underflow;

  int checks = 0;
  int errors = 0;

  mantissa_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_cout(in_cout), .in_op(in_op),
    .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  // Present one operand, return cycles from the load edge until out_valid (bounded).
  task automatic run_op(input logic op, input logic cout, input logic [23:0] mant,
                        input logic [7:0] exp, input logic sign, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_cout = cout; in_mant = mant; in_exp = exp; in_sign = sign;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    checks++;
    if ({out_mant, out_exp, out_sign, out_zero, out_overflow, out_underflow} !== 36'h0) begin
      errors++; $display("FAIL reset_data got mant=%h exp=%h s=%b z=%b o=%b u=%b want all 0",
                         out_mant, out_exp, out_sign, out_zero, out_overflow, out_underflow);
    end
  endtask

  task automatic test_carry();
    int lat;
    run_op(1'b0, 1'b1, 24'h800000, 8'h80, 1'b0, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL carry_lat got %0d want 1", lat); end
    checks++;
    if (out_mant !== 24'hC00000 || out_exp !== 8'h81 || out_sign !== 1'b0 ||
        {out_zero, out_overflow, out_underflow} !== 3'b000) begin
      errors++; $display("FAIL carry_res got mant=%h exp=%h s=%b zou=%b%b%b want C00000 81 0 000",
                         out_mant, out_exp, out_sign, out_zero, out_overflow, out_underflow);
    end
    finish_op();
  endtask

  task automatic test_sub_shift();
    int lat;
    int exp_lat;
`ifdef NORM_SHIFT4_EN
    exp_lat = 6;
`else
    exp_lat = 15;
`endif
    run_op(1'b1, 1'b1, 24'h000300, 8'h90, 1'b1, lat);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL sub_lat got %0d want %0d", lat, exp_lat); end
    checks++;
    if (out_mant !== 24'hC00000 || out_exp !== 8'h82 || out_sign !== 1'b1 || out_underflow !== 1'b0) begin
      errors++; $display("FAIL sub_res got mant=%h exp=%h s=%b u=%b want C00000 82 1 0",
                         out_mant, out_exp, out_sign, out_underflow);
    end
    finish_op();
  endtask

  task automatic test_borrow();
    int lat;
    int exp_lat;
`ifdef NORM_SHIFT4_EN
    exp_lat = 9;
`else
    exp_lat = 24;
`endif
    run_op(1'b1, 1'b0, 24'hFFFFFF, 8'h80, 1'b0, lat);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL borrow_lat got %0d want %0d", lat, exp_lat); end
    checks++;
    if (out_mant !== 24'h800000 || out_exp !== 8'h69 || out_sign !== 1'b1 ||
        {out_zero, out_overflow, out_underflow} !== 3'b000) begin
      errors++; $display("FAIL borrow_res got mant=%h exp=%h s=%b want 800000 69 1", out_mant, out_exp, out_sign);
    end
    finish_op();
  endtask

  task automatic test_zero_overflow();
    int lat;
    run_op(1'b1, 1'b1, 24'h000000, 8'h55, 1'b0, lat);
    checks++;
    if (lat !== 1 || out_zero !== 1'b1 || out_exp !== 8'h00 || out_mant !== 24'h0 ||
        out_overflow !== 1'b0 || out_underflow !== 1'b0) begin
      errors++; $display("FAIL zero got lat=%0d z=%b exp=%h mant=%h want 1 1 00 000000", lat, out_zero, out_exp, out_mant);
    end
    finish_op();
    run_op(1'b0, 1'b1, 24'h123456, 8'hFE, 1'b0, lat);
    checks++;
    if (lat !== 1 || out_overflow !== 1'b1 || out_exp !== 8'hFF || out_mant !== 24'h0 ||
        out_zero !== 1'b0 || out_underflow !== 1'b0) begin
      errors++; $display("FAIL overflow got lat=%0d o=%b exp=%h mant=%h want 1 1 FF 000000", lat, out_overflow, out_exp, out_mant);
    end
    finish_op();
  endtask

  task automatic test_normalized();
    int lat;
    run_op(1'b0, 1'b0, 24'h812345, 8'h40, 1'b1, lat);
    checks++;
    if (lat !== 1 || out_mant !== 24'h812345 || out_exp !== 8'h40 || out_sign !== 1'b1 ||
        {out_zero, out_overflow, out_underflow} !== 3'b000) begin
      errors++; $display("FAIL norm got lat=%0d mant=%h exp=%h s=%b want 1 812345 40 1", lat, out_mant, out_exp, out_sign);
    end
    finish_op();
  endtask

  task automatic test_underflow();
    int lat;
    run_op(1'b0, 1'b0, 24'h000001, 8'h03, 1'b0, lat);
    checks++;
    if (lat !== 3 || out_mant !== 24'h000004 || out_exp !== 8'h00 || out_underflow !== 1'b1) begin
      errors++; $display("FAIL unf_shift got lat=%0d mant=%h exp=%h u=%b want 3 000004 00 1", lat, out_mant, out_exp, out_underflow);
    end
    finish_op();
    run_op(1'b0, 1'b0, 24'h000010, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 1 || out_mant !== 24'h000010 || out_exp !== 8'h00 || out_underflow !== 1'b1 ||
        out_zero !== 1'b0) begin
      errors++; $display("FAIL unf_imm got lat=%0d mant=%h exp=%h u=%b want 1 000010 00 1", lat, out_mant, out_exp, out_underflow);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(1'b0, 1'b1, 24'h800000, 8'h80, 1'b0, lat);
    // Stall 3 cycles with a competing input that must be ignored.
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b1; in_cout = 1'b1; in_mant = 24'h0; in_exp = 8'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mant !== 24'hC00000 ||
          out_exp !== 8'h81 || out_zero !== 1'b0) begin
        errors++; $display("FAIL stall%0d got vld=%b rdy=%b mant=%h exp=%h want 1 0 C00000 81",
                           i, out_valid, in_ready, out_mant, out_exp);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL xfer got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_cout = 1'b0; in_mant = 24'h000001; in_exp = 8'h80; in_sign = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midshift got rdy=%b vld=%b want 0 0", in_ready, out_valid);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mant !== 24'h0) begin
      errors++; $display("FAIL rst_shift got vld=%b rdy=%b mant=%h want 0 1 000000", out_valid, in_ready, out_mant);
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_abandon got vld=%b want 0", out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mant = '0; in_cout = 1'b0; in_op = 1'b0; in_exp = '0; in_sign = 1'b0;
    test_reset();
    test_carry();
    test_sub_shift();
    test_borrow();
    test_zero_overflow();
    test_normalized();
    test_underflow();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
